// File: rtl/riscv_i32_trace_unpack.sv
// riscv_i32_trace_unpack
//
// Trace replay decoder. Consumes a packed stream of 32-bit trace words over a
// valid/ready handshake, reassembles each record and drives the RISC-V i32
// trace bus with one retired instruction per record.
//
// Ports:
//   clk, clk__enable, reset   clock, clock enable, async active-high reset
//   in_valid/in_data/in_ready packed word input handshake
//   trace__*                  decoded record, instr_valid pulses once per record
//   format_error              sticky, set when a header has bad magic
//   record_count              number of records emitted (wraps)
module riscv_i32_trace_unpack (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        trace__instr_valid,
    output logic [31:0] trace__instr_pc,
    output logic [31:0] trace__instr_data,
    output logic        trace__rfw_retire,
    output logic        trace__rfw_data_valid,
    output logic [4:0]  trace__rfw_rd,
    output logic [31:0] trace__rfw_data,
    output logic        trace__branch_taken,
    output logic [31:0] trace__branch_target,
    output logic        trace__trap,
    output logic        format_error,
    output logic [31:0] record_count
);

    typedef enum logic [2:0] {StHdr, StPc, StInstr, StRfw, StBr} state_e;

    state_e      state_q;
    logic        retire_q;
    logic        dv_q;
    logic [4:0]  rd_q;
    logic        br_q;
    logic        trap_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] rfw_q;
    logic [31:0] next_pc_q;

    logic        accept;
    logic        hdr_ok;
    logic        emit;
    logic [31:0] emit_instr;
    logic [31:0] emit_rfw;
    logic [31:0] emit_tgt;
    logic [31:0] emit_next_pc;

    // The record's last word is emitted straight from in_data, so fields that
    // can be final are muxed between the live word and the collected value.
    always_comb begin
        accept       = in_valid & in_ready & clk__enable;
        hdr_ok       = (in_data[31:28] == 4'hA);
        emit         = accept & (((state_q == StInstr) & ~dv_q & ~br_q) |
                                 ((state_q == StRfw) & ~br_q) |
                                 (state_q == StBr));
        emit_instr   = (state_q == StInstr) ? in_data : instr_q;
        emit_rfw     = dv_q ? ((state_q == StRfw) ? in_data : rfw_q) : 32'd0;
        // When a branch is present its target is always the final word.
        emit_tgt     = br_q ? in_data : 32'd0;
        emit_next_pc = br_q ? in_data : pc_q + 32'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q               <= StHdr;
            retire_q              <= 1'b0;
            dv_q                  <= 1'b0;
            rd_q                  <= 5'd0;
            br_q                  <= 1'b0;
            trap_q                <= 1'b0;
            pc_q                  <= 32'd0;
            instr_q               <= 32'd0;
            rfw_q                 <= 32'd0;
            next_pc_q             <= 32'd0;
            in_ready              <= 1'b0;
            trace__instr_valid    <= 1'b0;
            trace__instr_pc       <= 32'd0;
            trace__instr_data     <= 32'd0;
            trace__rfw_retire     <= 1'b0;
            trace__rfw_data_valid <= 1'b0;
            trace__rfw_rd         <= 5'd0;
            trace__rfw_data       <= 32'd0;
            trace__branch_taken   <= 1'b0;
            trace__branch_target  <= 32'd0;
            trace__trap           <= 1'b0;
            format_error          <= 1'b0;
            record_count          <= 32'd0;
        end else if (clk__enable) begin
            in_ready           <= 1'b1;
            trace__instr_valid <= emit;

            if (accept) begin
                case (state_q)
                    StHdr: begin
                        if (hdr_ok) begin
                            retire_q <= in_data[0];
                            dv_q     <= in_data[1];
                            rd_q     <= in_data[6:2];
                            br_q     <= in_data[7];
                            trap_q   <= in_data[8];
                            // Implicit PC; overwritten by the PC word if present.
                            pc_q     <= next_pc_q;
                            state_q  <= in_data[9] ? StPc : StInstr;
                        end else begin
                            format_error <= 1'b1;
                        end
                    end
                    StPc: begin
                        pc_q    <= in_data;
                        state_q <= StInstr;
                    end
                    StInstr: begin
                        instr_q <= in_data;
                        state_q <= dv_q ? StRfw : (br_q ? StBr : StHdr);
                    end
                    StRfw: begin
                        rfw_q   <= in_data;
                        state_q <= br_q ? StBr : StHdr;
                    end
                    StBr: begin
                        state_q <= StHdr;
                    end
                    default: begin
                        state_q <= StHdr;
                    end
                endcase
            end

            if (emit) begin
                trace__instr_pc       <= pc_q;
                trace__instr_data     <= emit_instr;
                trace__rfw_retire     <= retire_q;
                trace__rfw_data_valid <= dv_q;
                trace__rfw_rd         <= rd_q;
                trace__rfw_data       <= emit_rfw;
                trace__branch_taken   <= br_q;
                trace__branch_target  <= emit_tgt;
                trace__trap           <= trap_q;
                record_count          <= record_count + 32'd1;
                next_pc_q             <= emit_next_pc;
            end
        end
    end

endmodule

// File: tb/tb_riscv_i32_trace_unpack.sv
module tb_riscv_i32_trace_unpack;

    logic        clk;
    logic        clk__enable;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        trace__instr_valid;
    logic [31:0] trace__instr_pc;
    logic [31:0] trace__instr_data;
    logic        trace__rfw_retire;
    logic        trace__rfw_data_valid;
    logic [4:0]  trace__rfw_rd;
    logic [31:0] trace__rfw_data;
    logic        trace__branch_taken;
    logic [31:0] trace__branch_target;
    logic        trace__trap;
    logic        format_error;
    logic [31:0] record_count;

    int n_checks = 0;
    int n_errors = 0;

    riscv_i32_trace_unpack dut (
        .clk                   (clk),
        .clk__enable           (clk__enable),
        .reset                 (reset),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_ready              (in_ready),
        .trace__instr_valid    (trace__instr_valid),
        .trace__instr_pc       (trace__instr_pc),
        .trace__instr_data     (trace__instr_data),
        .trace__rfw_retire     (trace__rfw_retire),
        .trace__rfw_data_valid (trace__rfw_data_valid),
        .trace__rfw_rd         (trace__rfw_rd),
        .trace__rfw_data       (trace__rfw_data),
        .trace__branch_taken   (trace__branch_taken),
        .trace__branch_target  (trace__branch_target),
        .trace__trap           (trace__trap),
        .format_error          (format_error),
        .record_count          (record_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_retire;
        logic        e_dv;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_br;
        logic [31:0] e_tgt;
        logic        e_trap;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one word for a single enabled cycle, then check the pulse.
    task automatic send(input logic [31:0] w, input logic exp_pulse);
        in_valid = 1'b1;
        in_data  = w;
        chk("in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("instr_valid", {31'd0, trace__instr_valid}, {31'd0, exp_pulse});
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 32'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero();
        chk("rst instr_valid", {31'd0, trace__instr_valid}, 32'd0);
        chk("rst pc", trace__instr_pc, 32'd0);
        chk("rst instr", trace__instr_data, 32'd0);
        chk("rst retire", {31'd0, trace__rfw_retire}, 32'd0);
        chk("rst dv", {31'd0, trace__rfw_data_valid}, 32'd0);
        chk("rst rd", {27'd0, trace__rfw_rd}, 32'd0);
        chk("rst rfw_data", trace__rfw_data, 32'd0);
        chk("rst br", {31'd0, trace__branch_taken}, 32'd0);
        chk("rst tgt", trace__branch_target, 32'd0);
        chk("rst trap", {31'd0, trace__trap}, 32'd0);
        chk("rst format_error", {31'd0, format_error}, 32'd0);
        chk("rst count", record_count, 32'd0);
    endtask

    initial begin
        //        hdr           pc            instr         data          tgt
        //        e_pc          ret   dv    rd    e_data        br    e_tgt         trap  count
        vecs[0] = '{32'hA0000000, 32'h0, 32'h00000013, 32'h0, 32'h0,
                    32'h00000000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd1};
        vecs[1] = '{32'hA000038F, 32'h1000, 32'h0040006F, 32'h1004, 32'h2000,
                    32'h00001000, 1'b1, 1'b1, 5'd3, 32'h1004, 1'b1, 32'h2000, 1'b1, 32'd2};
        vecs[2] = '{32'hA0000000, 32'h0, 32'h00000033, 32'h0, 32'h0,
                    32'h00002000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd3};
        vecs[3] = '{32'hA0000017, 32'h0, 32'h00500093, 32'h5, 32'h0,
                    32'h00002004, 1'b1, 1'b1, 5'd5, 32'h5, 1'b0, 32'h0, 1'b0, 32'd4};
        vecs[4] = '{32'hA0000200, 32'hFFFFFFFC, 32'h00000013, 32'h0, 32'h0,
                    32'hFFFFFFFC, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd5};
        vecs[5] = '{32'hA0000000, 32'h0, 32'h00000013, 32'h0, 32'h0,
                    32'h00000000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd6};
        vecs[6] = '{32'hA0000101, 32'h0, 32'h00000073, 32'h0, 32'h0,
                    32'h00000004, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 32'd7};
        vecs[7] = '{32'hA0000080, 32'h0, 32'h00000063, 32'h0, 32'h100,
                    32'h00000008, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 1'b0, 32'd8};
        vecs[8] = '{32'hA0000000, 32'h0, 32'h00000013, 32'h0, 32'h0,
                    32'h00000100, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd9};
        vecs[9] = '{32'hAFFFFC00, 32'h0, 32'h00000013, 32'h0, 32'h0,
                    32'h00000104, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd10};

        clk__enable = 1'b1;
        in_valid    = 1'b0;
        in_data     = 32'd0;
        reset       = 1'b1;
        #12;
        chk_zero();
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("in_ready before clk", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready after clk", {31'd0, in_ready}, 32'd1);

        // Records back to back, in_valid held high throughout.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].hdr, 1'b0);
            if (vecs[i].hdr[9]) send(vecs[i].pc, 1'b0);
            send(vecs[i].instr, !(vecs[i].hdr[1] | vecs[i].hdr[7]));
            if (vecs[i].hdr[1]) send(vecs[i].data, !vecs[i].hdr[7]);
            if (vecs[i].hdr[7]) send(vecs[i].tgt, 1'b1);
            chk("pc", trace__instr_pc, vecs[i].e_pc);
            chk("instr", trace__instr_data, vecs[i].instr);
            chk("retire", {31'd0, trace__rfw_retire}, {31'd0, vecs[i].e_retire});
            chk("dv", {31'd0, trace__rfw_data_valid}, {31'd0, vecs[i].e_dv});
            chk("rd", {27'd0, trace__rfw_rd}, {27'd0, vecs[i].e_rd});
            chk("rfw_data", trace__rfw_data, vecs[i].e_data);
            chk("br", {31'd0, trace__branch_taken}, {31'd0, vecs[i].e_br});
            chk("tgt", trace__branch_target, vecs[i].e_tgt);
            chk("trap", {31'd0, trace__trap}, {31'd0, vecs[i].e_trap});
            chk("count", record_count, vecs[i].e_count);
        end
        idle();
        chk("pulse one cycle", {31'd0, trace__instr_valid}, 32'd0);
        chk("no format_error", {31'd0, format_error}, 32'd0);

        // Clock enable low: no word accepted, and the pulse holds.
        send(32'hA0000000, 1'b0);
        clk__enable = 1'b0;
        in_valid    = 1'b1;
        in_data     = 32'h00000013;
        repeat (2) @(posedge clk);
        #1;
        chk("en low no pulse", {31'd0, trace__instr_valid}, 32'd0);
        chk("en low count", record_count, 32'd10);
        clk__enable = 1'b1;
        send(32'h00000013, 1'b1);
        chk("en pc", trace__instr_pc, 32'h00000108);
        in_valid    = 1'b0;
        clk__enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("en low pulse hold", {31'd0, trace__instr_valid}, 32'd1);
        clk__enable = 1'b1;
        idle();
        chk("en pulse drop", {31'd0, trace__instr_valid}, 32'd0);
        chk("en count", record_count, 32'd11);

        // Bad magic header is dropped and flags format_error.
        do_reset();
        send(32'h50000000, 1'b0);
        chk("bad magic flag", {31'd0, format_error}, 32'd1);
        send(32'hA0000000, 1'b0);
        send(32'h00000013, 1'b1);
        chk("bad magic pc", trace__instr_pc, 32'd0);
        chk("bad magic count", record_count, 32'd1);
        idle();
        chk("format_error sticky", {31'd0, format_error}, 32'd1);

        // Reset in the middle of a record.
        send(32'hA0000200, 1'b0);
        send(32'h12345678, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk_zero();
        chk("mid rst in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(32'hA0000000, 1'b0);
        send(32'h00000013, 1'b1);
        chk("post rst pc", trace__instr_pc, 32'd0);
        chk("post rst count", record_count, 32'd1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_i32_trace_unpack.md
# riscv_i32_trace_unpack

Trace replay decoder: accepts a packed stream of 32-bit trace words over a valid/ready handshake, reassembles each record and drives the RISC-V i32 trace bus, one retired instruction per record. It sits between a trace capture memory or host FIFO and any trace-bus consumer, such as the trace monitor or the compare logic. It is the decoder for trace packing, so captured execution can be replayed cycle-accurately into trace sinks.

## Interface
- No parameters.
- clk  input  1  clock for all state
- clk__enable  input  1  clock enable; no state changes when low
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  packed word present
- in_data  input  32  packed trace word
- in_ready  output  1  word accepted when in_valid & in_ready & clk__enable
- trace__instr_valid  output  1  one-cycle pulse per decoded record
- trace__instr_pc  output  32  PC of the record
- trace__instr_data  output  32  instruction word
- trace__rfw_retire  output  1  register-file write retired
- trace__rfw_data_valid  output  1  rfw_data field valid
- trace__rfw_rd  output  5  destination register
- trace__rfw_data  output  32  write data
- trace__branch_taken  output  1  branch/jump taken
- trace__branch_target  output  32  branch target
- trace__trap  output  1  record trapped
- format_error  output  1  sticky; set on a bad header
- record_count  output  32  records emitted, wraps modulo 2^32

## Operation
- Header word fields:
  - [31:28] magic 4'hA
  - [0] rfw_retire
  - [1] rfw_data_valid
  - [6:2] rd
  - [7] branch_taken
  - [8] trap
  - [9] pc_explicit
  - [27:10] ignored
- Word order after the header:
  - pc, only if pc_explicit
  - instr, always
  - rfw_data, only if rfw_data_valid
  - branch_target, only if branch_taken
- FSM states: HDR → PC → INSTR → RFW → BR → HDR. Any state whose field is absent is skipped.
- State advances only on an accepted word.
- in_ready is 1 in every state once out of reset; there is no output backpressure.
- Header rejection: a header with magic ≠ 4'hA is consumed and discarded, sets format_error, and the FSM stays in HDR.
- format_error clears only on reset.
- next_pc register:
  - reset value 0
  - used as instr_pc when pc_explicit = 0
  - after each record: next_pc = branch_taken ? branch_target : pc + 4, with 32-bit wraparound
  - trap does not alter this rule
- Record emission: when the final word of a record is accepted, all trace__* fields are registered from the collected fields and trace__instr_valid is set.
- Omitted data fields are output as 0 (rfw_data when rfw_data_valid = 0; branch_target when branch_taken = 0).
- Field outputs hold until the next emission.
- trace__instr_valid deasserts on the next enabled clock.
- record_count increments by 1 per emission.

## Timing
- Reset value of every output is 0, except in_ready, which is 0 during reset and 1 from the first enabled clock after reset deasserts. FSM resets to HDR and next_pc to 0.
- Latency: trace__instr_valid is high in the cycle after the final word is accepted, for exactly one enabled cycle.
- Back-to-back records: the next header may be accepted in the same cycle that trace__instr_valid is high, so there are no bubbles.
- Minimum record size is 2 words, so instr_valid never stays high for two consecutive cycles.
- clk__enable low: all registers, including the instr_valid pulse, hold.
- Reset asserted mid-record discards the partial record and returns all state to reset values immediately (asynchronous).

## Test plan
- Minimal record after reset: header 0xA0000000, instr 0x00000013 → one pulse with pc = 0x0, instr = 0x00000013, other fields 0. Then next_pc = 0x4 and record_count = 1.
- Full record: header 0xA000038D (retire = 1, data_valid = 0, rd = 3, branch = 1, trap = 1, pc_explicit = 1) is illegal with data_valid = 0 on this bench. Use 0xA000038F instead (retire = 1, data_valid = 1, rd = 3, branch = 1, trap = 1, pc_explicit = 1), followed by pc 0x1000, instr 0x0040006F, data 0x1004, target 0x2000.
  - Expect a single pulse with pc = 0x1000, instr = 0x0040006F, rd = 3, rfw_data = 0x1004, target = 0x2000, trap = 1.
  - Expect next_pc = 0x2000.
- Back-to-back: three minimal records with in_valid held high → in_ready stays high, pulses occur every 2 cycles, PCs are 0x0, 0x4, 0x8, and record_count = 3.
- Bad magic: header 0x50000000, then a valid minimal record → format_error = 1, the bad word is dropped, and the valid record emits with pc = 0x0.
- PC wrap: explicit pc 0xFFFFFFFC with no branch, then an implicit record → second pc = 0x00000000.
- Reset mid-record: assert reset after header and pc words → no pulse, all outputs 0. A subsequent minimal record emits with pc = 0x0 and record_count = 1.
